// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST controller: FSM states, LFSR/MISR
// feedback polynomials per width, seed substitution and wait-latency limits.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Galois right-shift feedback masks
    localparam logic [7:0]  POLY_8  = 8'hB8;
    localparam logic [15:0] POLY_16 = 16'hB400;
    localparam logic [31:0] POLY_32 = 32'h8020_0003;

    localparam int unsigned SEED_ZERO_SUB = 1;
    localparam int unsigned LAT_MAX       = 15;
    localparam int unsigned LAT_CNT_W     = 4;
    localparam int unsigned VEC_CNT_W     = 16;

    function automatic logic [31:0] poly_for(input int unsigned w);
        case (w)
            8:       return 32'(POLY_8);
            32:      return POLY_32;
            default: return 32'(POLY_16);
        endcase
    endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Stimulus/response bundle between the BIST controller and its harness.
// Optional abort input present when ALU_BIST_ABORT_EN is defined.
interface alu_bist_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RES_W = 16
);
    logic                 start;
    logic [15:0]          num_vec;
    logic [2*WIDTH-1:0]   seed;
    logic [RES_W-1:0]     exp_sig;
    logic [RES_W-1:0]     res_in;
`ifdef ALU_BIST_ABORT_EN
    logic                 abort;
`endif
    logic [WIDTH-1:0]     a_out;
    logic [WIDTH-1:0]     b_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [RES_W-1:0]     signature;
    logic [15:0]          vec_cnt;

    // Controller side
    modport master (
`ifdef ALU_BIST_ABORT_EN
        input  abort,
`endif
        input  start, num_vec, seed, exp_sig, res_in,
        output a_out, b_out, busy, done, pass, signature, vec_cnt
    );

    // Harness side
    modport slave (
`ifdef ALU_BIST_ABORT_EN
        output abort,
`endif
        output start, num_vec, seed, exp_sig, res_in,
        input  a_out, b_out, busy, done, pass, signature, vec_cnt
    );

endinterface

// File: rtl/alu_bist_lfsr.sv
// Galois right-shift register with parallel load, step enable and data-in XOR.
// Serves both as the operand LFSR (din=0) and as the response MISR.
module alu_bist_lfsr #(
    parameter int unsigned   W    = 16,
    parameter logic [W-1:0]  POLY = W'(16'hB400)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (en_i) begin
            q_d = (q_q >> 1) ^ (q_q[0] ? POLY : '0) ^ din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller: drives LFSR operand pairs, captures results after LAT wait
// cycles into a MISR and compares the signature. Optional ALU_BIST_ABORT_EN.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RES_W = 16,
    parameter int unsigned LAT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    alu_bist_if.master bus
);

    localparam int unsigned     LW     = 2 * WIDTH;
    localparam logic [LW-1:0]   POLY_L = LW'(poly_for(LW));
    localparam logic [RES_W-1:0] POLY_M = RES_W'(poly_for(RES_W));

    state_e                 state_q;
    logic [LAT_CNT_W-1:0]   w_q;
    logic [VEC_CNT_W-1:0]   cnt_q;
    logic [VEC_CNT_W-1:0]   nv_q;
    logic [LW-1:0]          seed_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;

    logic                   abort_c;
    logic                   lat_hit_c;
    logic                   capture_c;
    logic                   load_c;
    logic [LW-1:0]          seed_eff_c;
    logic [LW-1:0]          lfsr_q;
    logic [RES_W-1:0]       misr_q;

`ifdef ALU_BIST_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    assign lat_hit_c  = (w_q == LAT_CNT_W'(LAT));
    assign capture_c  = (state_q == ST_APPLY) && lat_hit_c && !abort_c;
    assign load_c     = (state_q == ST_LOAD);
    // An all-zero seed would lock the LFSR, so substitute a non-zero one
    assign seed_eff_c = (seed_q == '0) ? LW'(SEED_ZERO_SUB) : seed_q;

    alu_bist_lfsr #(.W(LW), .POLY(POLY_L)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (seed_eff_c),
        .en_i       (capture_c),
        .din_i      (LW'(0)),
        .q_o        (lfsr_q)
    );

    alu_bist_lfsr #(.W(RES_W), .POLY(POLY_M)) u_misr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (RES_W'(0)),
        .en_i       (capture_c),
        .din_i      (bus.res_in),
        .q_o        (misr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            cnt_q     <= '0;
            nv_q      <= '0;
            seed_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q   <= ST_LOAD;
                        nv_q      <= bus.num_vec;
                        seed_q    <= bus.seed;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt_q <= '0;
                    w_q   <= '0;
                    if (abort_c) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (nv_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    // Abort wins over a capture landing in the same cycle
                    if (abort_c) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (lat_hit_c) begin
                        cnt_q <= cnt_q + VEC_CNT_W'(1);
                        w_q   <= '0;
                        if ((cnt_q + VEC_CNT_W'(1)) == nv_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        w_q <= w_q + LAT_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out     = lfsr_q[LW-1:WIDTH];
    assign bus.b_out     = lfsr_q[WIDTH-1:0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = done_q && !aborted_q && (misr_q == bus.exp_sig);
    assign bus.signature = misr_q;
    assign bus.vec_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (LAT=0 and LAT=2) share stimulus and are
// checked every cycle against a run-level timing model plus literal anchors.
module tb_alu_bist_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RES_W = 16;
`ifdef ALU_BIST_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] num_vec, seed, exp_sig, res_in;
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    int          lat_of [2] = '{0, 2};

    always #5 clk = ~clk;

    alu_bist_if #(.WIDTH(WIDTH), .RES_W(RES_W)) if0 ();
    alu_bist_if #(.WIDTH(WIDTH), .RES_W(RES_W)) if1 ();

    assign if0.start = start;     assign if1.start = start;
    assign if0.num_vec = num_vec; assign if1.num_vec = num_vec;
    assign if0.seed = seed;       assign if1.seed = seed;
    assign if0.exp_sig = exp_sig; assign if1.exp_sig = exp_sig;
    assign if0.res_in = res_in;   assign if1.res_in = res_in;
`ifdef ALU_BIST_ABORT_EN
    assign if0.abort = abort;     assign if1.abort = abort;
`endif

    alu_bist_ctrl #(.WIDTH(WIDTH), .RES_W(RES_W), .LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    alu_bist_ctrl #(.WIDTH(WIDTH), .RES_W(RES_W), .LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [7:0]  a_act [2];
    logic [7:0]  b_act [2];
    logic        busy_act [2];
    logic        done_act [2];
    logic        pass_act [2];
    logic [15:0] sig_act [2];
    logic [15:0] cnt_act [2];

    assign a_act[0] = if0.a_out;        assign a_act[1] = if1.a_out;
    assign b_act[0] = if0.b_out;        assign b_act[1] = if1.b_out;
    assign busy_act[0] = if0.busy;      assign busy_act[1] = if1.busy;
    assign done_act[0] = if0.done;      assign done_act[1] = if1.done;
    assign pass_act[0] = if0.pass;      assign pass_act[1] = if1.pass;
    assign sig_act[0] = if0.signature;  assign sig_act[1] = if1.signature;
    assign cnt_act[0] = if0.vec_cnt;    assign cnt_act[1] = if1.vec_cnt;

    // Reference model: phase, edges since start, operand sequence and folded signature
    int          m_ph [2];
    int          m_t  [2];
    int          m_n  [2];
    logic [15:0] m_sd [2];
    logic [15:0] m_lf [2];
    logic [15:0] m_ms [2];
    int          m_cnt [2];
    bit          m_ab [2];

    function automatic logic [15:0] gstep(input logic [15:0] x, input logic [15:0] din);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000) ^ din;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %h want %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int d);
        int  L;
        bit  ab_on;
        L     = lat_of[d];
        ab_on = ABORT_EN && (abort === 1'b1);
        if (rst) begin
            m_ph[d] = P_IDLE; m_lf[d] = '0; m_ms[d] = '0; m_cnt[d] = 0; m_ab[d] = 1'b0;
        end else if (m_ph[d] != P_RUN) begin
            if (start) begin
                m_ph[d] = P_RUN; m_t[d] = 0; m_n[d] = int'(num_vec); m_sd[d] = seed; m_ab[d] = 1'b0;
            end
        end else begin
            m_t[d]++;
            if (m_t[d] == 1) begin
                m_lf[d]  = (m_sd[d] == 16'h0) ? 16'h0001 : m_sd[d];
                m_ms[d]  = '0;
                m_cnt[d] = 0;
                if (ab_on) begin
                    m_ph[d] = P_DONE; m_ab[d] = 1'b1;
                end else if (m_n[d] == 0) begin
                    m_ph[d] = P_DONE;
                end
            end else if (ab_on) begin
                m_ph[d] = P_DONE; m_ab[d] = 1'b1;
            end else if (((m_t[d] - 2) % (L + 1)) == L) begin
                m_ms[d] = gstep(m_ms[d], res_in);
                m_lf[d] = gstep(m_lf[d], 16'h0000);
                m_cnt[d]++;
                if (m_cnt[d] == m_n[d]) m_ph[d] = P_DONE;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_edge(d);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("a_out", d, 32'(a_act[d]), 32'(m_lf[d][15:8]));
                chk("b_out", d, 32'(b_act[d]), 32'(m_lf[d][7:0]));
                chk("busy", d, 32'(busy_act[d]), 32'(m_ph[d] == P_RUN));
                chk("done", d, 32'(done_act[d]), 32'(m_ph[d] == P_DONE));
                chk("pass", d, 32'(pass_act[d]),
                    32'((m_ph[d] == P_DONE) && !m_ab[d] && (m_ms[d] == exp_sig)));
                chk("signature", d, 32'(sig_act[d]), 32'(m_ms[d]));
                chk("vec_cnt", d, 32'(cnt_act[d]), 32'(m_cnt[d]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] first_a, first_b;

    // One run: pulse start, feed res_in each cycle, measure edges until done
    task automatic run(input logic [15:0] s, input int nv, input bit rnd, input logic [15:0] cres,
                       input int extra_start_at, input int abort_at, output int dt0, output int dt1);
        int bound;
        bound   = 6 + nv * 3;
        seed    = s;
        num_vec = 16'(nv);
        res_in  = cres;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        dt0 = -1;
        dt1 = -1;
        for (int e = 1; e <= bound; e++) begin
            res_in = rnd ? 16'($urandom) : cres;
            start  = (e == extra_start_at);
            abort  = (e == abort_at);
            cyc();
            if (e == 1) begin
                first_a = a_act[0];
                first_b = b_act[0];
            end
            if (done_act[0] && dt0 < 0) dt0 = e;
            if (done_act[1] && dt1 < 0) dt1 = e;
            if (dt0 >= 0 && dt1 >= 0) break;
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at < 0 || !ABORT_EN) begin
            chk("done_latency", 0, 32'(dt0), 32'(1 + nv));
            chk("done_latency", 1, 32'(dt1), 32'(1 + nv * 3));
        end
    endtask

    initial begin
        int dt0, dt1;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_vec = '0; seed = '0; exp_sig = '0; res_in = '0;
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = P_IDLE; m_t[d] = 0; m_n[d] = 0; m_sd[d] = '0;
            m_lf[d] = '0; m_ms[d] = '0; m_cnt[d] = 0; m_ab[d] = 1'b0;
        end
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_sig", 0, 32'(sig_act[0]), 32'h0);
        chk("rst_ab", 0, 32'({a_act[0], b_act[0]}), 32'h0);
        chk("rst_flags", 0, 32'({busy_act[0], done_act[0], pass_act[0]}), 32'h0);
        cyc();

        // Single vector
        exp_sig = 16'h1234;
        run(16'h0001, 1, 1'b0, 16'h1234, -1, -1, dt0, dt1);
        chk("one_first_ab", 0, 32'({first_a, first_b}), 32'h0001);
        chk("one_sig", 0, 32'(sig_act[0]), 32'h1234);
        chk("one_cnt", 0, 32'(cnt_act[0]), 32'd1);
        chk("one_lat", 0, 32'(dt0), 32'd2);
        chk("one_next_ab", 0, 32'({a_act[0], b_act[0]}), 32'hB400);

        // Two vectors, pass then miss
        exp_sig = 16'h1B2E;
        run(16'h0001, 2, 1'b0, 16'h1234, -1, -1, dt0, dt1);
        chk("two_sig", 0, 32'(sig_act[0]), 32'h1B2E);
        chk("two_sig", 1, 32'(sig_act[1]), 32'h1B2E);
        chk("two_pass", 0, 32'(pass_act[0]), 32'd1);
        exp_sig = 16'h1B2F;
        cyc();
        chk("two_nopass", 0, 32'(pass_act[0]), 32'd0);

        // Zero seed behaves as seed 1
        exp_sig = 16'h1B2E;
        run(16'h0000, 2, 1'b0, 16'h1234, -1, -1, dt0, dt1);
        chk("seed0_ab", 0, 32'({first_a, first_b}), 32'h0001);
        chk("seed0_sig", 0, 32'(sig_act[0]), 32'h1B2E);

        // Latency with glitching res_in
        run(16'($urandom), 3, 1'b1, 16'h0, -1, -1, dt0, dt1);
        chk("lat2_done", 1, 32'(dt1), 32'd10);

        // Zero vectors
        run(16'hBEEF, 0, 1'b1, 16'h0, -1, -1, dt0, dt1);
        chk("nv0_sig", 0, 32'(sig_act[0]), 32'h0);
        chk("nv0_lat", 0, 32'(dt0), 32'd1);

        // Restart from DONE twice, and start while busy
        exp_sig = 16'h0;
        run(16'hACE1, 4, 1'b0, 16'h5A5A, -1, -1, dt0, dt1);
        run(16'hACE1, 4, 1'b0, 16'h5A5A, -1, -1, dt0, dt1);
        run(16'h1357, 4, 1'b1, 16'h0, 2, -1, dt0, dt1);

        // Reset mid-APPLY
        seed = 16'h2468; num_vec = 16'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_sig", 0, 32'(sig_act[0]), 32'h0);
        chk("midrst_cnt", 1, 32'(cnt_act[1]), 32'h0);
        chk("midrst_flags", 0, 32'({busy_act[0], done_act[0], a_act[0], b_act[0]}), 32'h0);
        cyc();

        // Random runs
        for (int k = 0; k < 8; k++) begin
            exp_sig = 16'($urandom);
            run(16'($urandom), int'($urandom_range(1, 9)), 1'b1, 16'h0, -1, -1, dt0, dt1);
            repeat (int'($urandom_range(0, 2))) cyc();
        end

`ifdef ALU_BIST_ABORT_EN
        // Abort after two captures on the LAT=0 instance
        exp_sig = 16'h1B2E;
        run(16'h0001, 5, 1'b0, 16'h1234, -1, 4, dt0, dt1);
        chk("abort_done", 0, 32'(done_act[0]), 32'd1);
        chk("abort_pass", 0, 32'(pass_act[0]), 32'd0);
        chk("abort_cnt", 0, 32'(cnt_act[0]), 32'd2);
        chk("abort_cnt", 1, 32'(cnt_act[1]), 32'd0);
`endif

        repeat (2) cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
